// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler: samples a COLS x ROWS pixel grid per frame and streams it out as header + RGB bytes
module matrix_frame_scheduler #(
  parameter int         COLS     = 16,
  parameter int         ROWS     = 8,
  parameter int         X0       = 0,
  parameter int         X_STEP   = 40,
  parameter int         Y0       = 0,
  parameter int         Y_STEP   = 60,
  parameter bit         VS_POL   = 1'b1,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pll_lock,
  input  logic       vs,
  input  logic       de,
  input  logic [7:0] rgb_r,
  input  logic [7:0] rgb_g,
  input  logic [7:0] rgb_b,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] drop_cnt
);
  localparam int NPIX = COLS * ROWS;
  localparam int AW = $clog2(NPIX);
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, SEND_HDR, SEND_PIX} state_t;
  state_t state_q, state_d;
  logic vs_q, de_q, vs_start, de_fall, hit, wr, accept, last, drop;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] pix_q, pix_d, raddr, waddr;
  logic [1:0] comp_q, comp_d;
  logic [15:0] cur_q, cur_d;
  logic [23:0] rdata_q;
  logic [23:0] mem [NPIX];
  logic [7:0] tx_data_q, tx_data_d, drop_cnt_q, drop_cnt_d;
  logic tx_valid_q, tx_valid_d, busy_q, busy_d, frame_done_q, frame_done_d;
  assign vs_start = (vs == VS_POL) && (vs_q != VS_POL);
  assign de_fall = de_q && !de;
  assign hit = de && col_q < CW'(COLS) && x_q == 12'(X0 + int'(col_q) * X_STEP) && y_q == 12'(Y0 + int'(row_q) * Y_STEP);
  assign wr = state_q == CAPTURE && hit;
  assign waddr = AW'(int'(row_q) * COLS + int'(col_q));
  assign raddr = state_q == SEND_PIX ? pix_q + AW'(1) : '0;
  assign accept = tx_valid_q && tx_ready;
  assign last = pix_q == AW'(NPIX - 1) && comp_q == 2'd2;
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy = busy_q;
  assign frame_done = frame_done_q;
  assign drop_cnt = drop_cnt_q;
  // next-state: sync counters, capture grid walk, byte sequencing with one-pixel prefetch
  always_comb begin
    state_d = state_q;
    x_d = de ? x_q + 12'd1 : de_fall ? '0 : x_q;
    y_d = vs_start ? '0 : de_fall ? y_q + 12'd1 : y_q;
    col_d = col_q;
    row_d = row_q;
    pix_d = pix_q;
    comp_d = comp_q;
    cur_d = cur_q;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q;
    frame_done_d = 1'b0;
    drop = 1'b0;
    case (state_q)
      IDLE: if (vs_start && enable && pll_lock) begin
        state_d = CAPTURE;
        col_d = '0;
        row_d = '0;
      end
      CAPTURE: if (vs_start || !pll_lock) begin
        state_d = IDLE;
        drop = 1'b1;
      end else begin
        if (hit) col_d = col_q + CW'(1);
        if (de_fall && col_q == CW'(COLS)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
          if (row_q == RW'(ROWS - 1)) begin
            state_d = SEND_HDR;
            tx_valid_d = 1'b1;
            tx_data_d = HDR_BYTE;
          end
        end
      end
      SEND_HDR: begin
        drop = vs_start && enable && pll_lock;
        if (accept) begin
          state_d = SEND_PIX;
          pix_d = '0;
          comp_d = '0;
          cur_d = rdata_q[15:0];
          tx_data_d = rdata_q[23:16];
        end
      end
      default: begin
        drop = vs_start && enable && pll_lock;
        if (accept) begin
          if (last) begin
            state_d = IDLE;
            tx_valid_d = 1'b0;
            frame_done_d = 1'b1;
          end else if (comp_q == 2'd2) begin
            comp_d = '0;
            pix_d = pix_q + AW'(1);
            cur_d = rdata_q[15:0];
            tx_data_d = rdata_q[23:16];
          end else begin
            comp_d = comp_q + 2'd1;
            tx_data_d = comp_q == 2'd0 ? cur_q[15:8] : cur_q[7:0];
          end
        end
      end
    endcase
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    busy_d = state_d != IDLE;
  end
  // control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vs_q <= VS_POL;
      de_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      col_q <= '0;
      row_q <= '0;
      pix_q <= '0;
      comp_q <= '0;
      cur_q <= '0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      vs_q <= vs;
      de_q <= de;
      x_q <= x_d;
      y_q <= y_d;
      col_q <= col_d;
      row_q <= row_d;
      pix_q <= pix_d;
      comp_q <= comp_d;
      cur_q <= cur_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  // pixel buffer with registered read
  always_ff @(posedge clk) begin
    if (wr) mem[waddr] <= {rgb_r, rgb_g, rgb_b};
    rdata_q <= mem[raddr];
  end
endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// tb_matrix_frame_scheduler: directed scoreboard bench for the frame scheduler
module tb_matrix_frame_scheduler;
  localparam int X0 = 1, XS = 4, Y0 = 2, YS = 3, W = 66, H = 26;
  logic clk = 1'b0;
  logic rst, enable, pll_lock, vs, de, tx_ready, tx_valid, busy, frame_done;
  logic [7:0] rgb_r, rgb_g, rgb_b, tx_data, drop_cnt;
  logic rnd_ready = 1'b0, ready_lvl = 1'b0, gap_chk = 1'b0, seen_valid = 1'b0, stall_q = 1'b0;
  logic [7:0] stall_data = '0;
  logic [7:0] q [$];
  int checks = 0, errors = 0, cyc = 0, first_cyc = 0, done_cnt = 0, xfer_cnt = 0, base;
  always #5 clk = ~clk;
  matrix_frame_scheduler #(.X0(X0), .X_STEP(XS), .Y0(Y0), .Y_STEP(YS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pll_lock(pll_lock), .vs(vs), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic vs_pulse();
    vs = 1'b1;
    repeat (3) step();
    vs = 1'b0;
    repeat (3) step();
  endtask
  task automatic frame(input int lines, input int pll_line);
    vs_pulse();
    for (int y = 0; y < lines; y++) begin
      if (y == pll_line) pll_lock = 1'b0;
      for (int x = 0; x < W; x++) begin
        de = 1'b1;
        rgb_r = x[7:0];
        rgb_g = y[7:0];
        rgb_b = 8'h5A;
        step();
      end
      de = 1'b0;
      rgb_r = '0;
      rgb_g = '0;
      rgb_b = '0;
      repeat (4) step();
    end
  endtask
  task automatic push_frame();
    q.push_back(8'hA5);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin
        q.push_back(8'(X0 + XS * c));
        q.push_back(8'(Y0 + YS * r));
        q.push_back(8'h5A);
      end
  endtask
  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) step();
    check("frame_done_count", done_cnt, target);
    check("queue_empty", q.size(), 0);
  endtask
  initial begin
    tx_ready = 1'b0;
    forever begin
      step();
      tx_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : ready_lvl;
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (stall_q) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, stall_data);
      end
      if (tx_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_cyc = cyc;
      end
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        if (q.size() == 0) check("spurious_byte", q.size(), 1);
        else check("byte", tx_data, q.pop_front());
      end
      if (frame_done) begin
        done_cnt++;
        if (gap_chk) check("no_gaps", cyc - first_cyc, 385);
      end
    end
    stall_q = !rst && tx_valid && !tx_ready;
    stall_data = tx_data;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    enable = 1'b0;
    pll_lock = 1'b1;
    vs = 1'b0;
    de = 1'b0;
    rgb_r = '0;
    rgb_g = '0;
    rgb_b = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    vs_pulse();
    vs_pulse();
    frame(H, -1);
    check("disabled_busy", busy, 0);
    check("disabled_drop", drop_cnt, 0);
    enable = 1'b1;
    ready_lvl = 1'b1;
    repeat (2) step();
    seen_valid = 1'b0;
    gap_chk = 1'b1;
    push_frame();
    frame(H, -1);
    wait_done(1, 3000);
    gap_chk = 1'b0;
    rnd_ready = 1'b1;
    push_frame();
    frame(H, -1);
    wait_done(2, 8000);
    rnd_ready = 1'b0;
    repeat (2) step();
    frame(20, -1);
    vs_pulse();
    check("short_drop", drop_cnt, 1);
    check("short_busy", busy, 0);
    frame(H, 10);
    pll_lock = 1'b1;
    step();
    check("pll_drop", drop_cnt, 2);
    check("pll_busy", busy, 0);
    ready_lvl = 1'b0;
    push_frame();
    frame(H, -1);
    frame(H, -1);
    check("b2b_drop", drop_cnt, 3);
    check("b2b_busy", busy, 1);
    ready_lvl = 1'b1;
    wait_done(3, 3000);
    ready_lvl = 1'b0;
    push_frame();
    frame(H, -1);
    enable = 1'b0;
    repeat (5) vs_pulse();
    check("send_disabled_drop", drop_cnt, 3);
    check("send_disabled_busy", busy, 1);
    enable = 1'b1;
    repeat (300) vs_pulse();
    check("drop_saturate", drop_cnt, 255);
    ready_lvl = 1'b1;
    wait_done(4, 3000);
    ready_lvl = 1'b0;
    push_frame();
    frame(H, -1);
    base = xfer_cnt;
    ready_lvl = 1'b1;
    for (int i = 0; i < 1000 && xfer_cnt - base < 50; i++) step();
    check("reach_byte_50", xfer_cnt - base >= 50, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    check("midrst_frame_done", frame_done, 0);
    step();
    rst = 1'b0;
    repeat (20) step();
    check("post_rst_done", done_cnt, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
